// File: rtl/run_control.sv
// Run/stop/step/fast control for a free-running counter: debounced pushbuttons
// drive a two-state FSM with a breakpoint that freezes the counter on bpValue.
module run_control #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        btnRun,
  input  logic        btnStop,
  input  logic        btnStep,
  input  logic        btnFast,
  input  logic        bpEnable,
  input  logic [31:0] bpValue,
  input  logic [31:0] count,
  output logic        enable,
  output logic        step,
  output logic        fast,
  output logic        running,
  output logic        bpHit
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STOPPED, RUNNING} state_t;

  state_t        state;
  logic          bp_mask;
  logic [3:0]    btn_raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    level;
  logic [3:0]    level_q;
  logic [3:0]    press;
  logic [CW-1:0] db_cnt [4];
  logic          bp_match;
  logic          run_press;
  logic          stop_press;
  logic          step_press;
  logic          fast_press;

  // Bit order: 0 run, 1 stop, 2 step, 3 fast.
  assign btn_raw = {btnFast, btnStep, btnStop, btnRun};

  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_q <= level;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press      = level & ~level_q;
  assign run_press  = press[0];
  assign stop_press = press[1];
  assign step_press = press[2];
  assign fast_press = press[3];

  // The mask lets a resumed run step off the breakpoint value it stopped on.
  assign bp_match = bpEnable && (count == bpValue) && !bp_mask;
  assign enable   = (state == RUNNING) && !bp_match;
  assign running  = (state == RUNNING);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= STOPPED;
      step    <= 1'b0;
      fast    <= 1'b0;
      bpHit   <= 1'b0;
      bp_mask <= 1'b0;
    end else begin
      step <= 1'b0;
      if (fast_press) fast <= ~fast;
      if (enable) bp_mask <= 1'b0;
      case (state)
        STOPPED: begin
          if (run_press && !stop_press) begin
            state   <= RUNNING;
            bp_mask <= 1'b1;
            bpHit   <= 1'b0;
          end else if (step_press) begin
            step <= 1'b1;
          end
        end
        RUNNING: begin
          if (bp_match) bpHit <= 1'b1;
          if (stop_press || bp_match) state <= STOPPED;
        end
        default: state <= STOPPED;
      endcase
    end
  end

endmodule

// File: tb/tb_run_control.sv
// Randomized bench for run_control: button ops feed a behavioural model that
// queues expected output events; a monitor pops and compares on each DUT event.
module tb_run_control;

  localparam int D = 4;
  localparam int W = 37;

  localparam int OP_RUN    = 0;
  localparam int OP_STOP   = 1;
  localparam int OP_STEP   = 2;
  localparam int OP_STEPB  = 3;
  localparam int OP_FAST   = 4;
  localparam int OP_BOTH   = 5;
  localparam int OP_ARM    = 6;
  localparam int OP_DISARM = 7;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        btnRun = 1'b0;
  logic        btnStop = 1'b0;
  logic        btnStep = 1'b0;
  logic        btnFast = 1'b0;
  logic        bpEnable = 1'b0;
  logic [31:0] bpValue = '0;
  logic [31:0] count = '0;
  logic        enable;
  logic        step;
  logic        fast;
  logic        running;
  logic        bpHit;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  bit mon_en = 1'b0;

  // model state
  bit          m_run = 1'b0;
  bit          m_fast = 1'b0;
  bit          m_hit = 1'b0;
  bit          bp_en = 1'b0;
  logic [31:0] bp_val = '0;

  run_control #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK(CLK), .reset(reset),
    .btnRun(btnRun), .btnStop(btnStop), .btnStep(btnStep), .btnFast(btnFast),
    .bpEnable(bpEnable), .bpValue(bpValue), .count(count),
    .enable(enable), .step(step), .fast(fast), .running(running), .bpHit(bpHit)
  );

  // clock / reset block and downstream counter model
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (enable || step) count <= count + 32'd1;
  end

  // event word: {has_count, step, running, fast, bpHit, count}
  function automatic logic [W-1:0] ev(input bit hc, input bit st, input bit r,
                                      input bit f, input bit h, input logic [31:0] c);
    return {hc, st, r, f, h, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // monitor / scoreboard
  logic [2:0] prev_flags = '0;
  logic       prev_step = 1'b0;

  always @(negedge CLK) begin : monitor
    logic [W-1:0] e;
    logic [2:0]   fl;
    fl = {running, fast, bpHit};
    if (mon_en) begin
      if (step) begin
        checks++;
        if (prev_step) begin
          failures++;
          $display("FAIL step_width actual=2+ cycles required=1 cycle");
        end
      end
      if ((step && !prev_step) || fl != prev_flags) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event actual step=%0b run/fast/hit=%b count=%0d required no event",
                   step, fl, count);
        end else begin
          e = exp_q.pop_front();
          if (e[35] != step || e[34:32] != fl || (e[36] && e[31:0] != count)) begin
            failures++;
            $display("FAIL event actual step=%0b run/fast/hit=%b count=%0d required step=%0b run/fast/hit=%b count=%0d%s",
                     step, fl, count, e[35], e[34:32], e[31:0], e[36] ? "" : "(any)");
          end
        end
      end
    end
    prev_flags = fl;
    prev_step  = step;
  end

  // driver tasks
  task automatic set_btn(input logic [3:0] m);
    @(negedge CLK);
    {btnFast, btnStep, btnStop, btnRun} = m;
  endtask

  task automatic press(input logic [3:0] m, input bit bounce);
    if (bounce) begin
      set_btn(m);
      repeat (1) @(negedge CLK);
      set_btn(4'b0000);
      repeat (1) @(negedge CLK);
    end
    set_btn(m);
    repeat (12) @(negedge CLK);
    set_btn(4'b0000);
    repeat (60) @(negedge CLK);
  endtask

  task automatic do_op(input int op);
    bit resume;
    case (op)
      OP_RUN: begin
        resume = 1'b0;
        if (!m_run) begin
          m_run = 1'b1;
          m_hit = 1'b0;
          exp_q.push_back(ev(0, 0, 1, m_fast, 0, 0));
          resume = bp_en && (bp_val == count);
          if (bp_en && bp_val > count) begin
            m_run = 1'b0;
            m_hit = 1'b1;
            exp_q.push_back(ev(1, 0, 0, m_fast, 1, bp_val));
          end
        end
        press(4'b0001, 1'b0);
        if (resume) begin
          checks++;
          if (!(count > bp_val)) begin
            failures++;
            $display("FAIL bp_resume actual count=%0d required above %0d", count, bp_val);
          end
        end
      end
      OP_STOP, OP_BOTH: begin
        if (m_run) begin
          m_run = 1'b0;
          exp_q.push_back(ev(0, 0, 0, m_fast, m_hit, 0));
        end
        press(op == OP_BOTH ? 4'b0011 : 4'b0010, 1'b0);
      end
      OP_STEP, OP_STEPB: begin
        if (!m_run) exp_q.push_back(ev(1, 1, 0, m_fast, m_hit, count));
        press(4'b0100, op == OP_STEPB);
      end
      OP_FAST: begin
        m_fast = !m_fast;
        exp_q.push_back(ev(0, 0, m_run, m_fast, m_hit, 0));
        press(4'b1000, 1'b0);
      end
      OP_ARM: begin
        if (!m_run) begin
          @(negedge CLK);
          bp_en    = 1'b1;
          bp_val   = count + 32'($urandom_range(5, 30));
          bpEnable = 1'b1;
          bpValue  = bp_val;
        end
      end
      default: begin
        @(negedge CLK);
        bp_en    = 1'b0;
        bpEnable = 1'b0;
      end
    endcase
  endtask

  initial begin : stim
    int lat;
    repeat (3) @(negedge CLK);
    check("reset_enable", 32'(enable), 0);
    check("reset_step", 32'(step), 0);
    check("reset_fast", 32'(fast), 0);
    check("reset_running", 32'(running), 0);
    check("reset_bphit", 32'(bpHit), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // directed: run/stop, bounced step, breakpoint and resume, simultaneous, fast twice
    do_op(OP_RUN);
    do_op(OP_STEPB);
    do_op(OP_STOP);
    do_op(OP_STEPB);
    do_op(OP_STOP);
    do_op(OP_ARM);
    do_op(OP_RUN);
    check("bp_stopped", 32'(running), 0);
    check("bp_count", count, bp_val);
    do_op(OP_RUN);
    do_op(OP_BOTH);
    do_op(OP_BOTH);
    do_op(OP_FAST);
    do_op(OP_FAST);

    for (int i = 0; i < 40; i++) do_op(int'($urandom_range(0, 7)));

    repeat (10) @(negedge CLK);
    check("events_left", 32'(exp_q.size()), 0);

    // reset while running with fast set
    do_op(OP_DISARM);
    if (!m_fast) do_op(OP_FAST);
    if (!m_run) do_op(OP_RUN);
    check("pre_reset_running", 32'(running), 1);
    check("pre_reset_fast", 32'(fast), 1);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge CLK);
    check("rst_outputs", {27'd0, enable, step, fast, running, bpHit}, 0);
    reset = 1'b0;
    repeat (20) @(negedge CLK);

    // button held across reset is accepted one full window after release
    btnRun = 1'b1;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    check("held_rst_running", 32'(running), 0);
    reset = 1'b0;
    lat = 0;
    while (!running && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    checks++;
    if (lat < 6 || lat > 8) begin
      failures++;
      $display("FAIL held_through_reset actual latency=%0d required 6..8", lat);
    end
    btnRun = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_control.md
RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable cycles a button level needs before it is accepted (10 ms at 100 MHz).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btnRun  input  1  raw asynchronous pushbutton; press requests run.
REQ-005 btnStop  input  1  raw asynchronous pushbutton; press requests stop.
REQ-006 btnStep  input  1  raw asynchronous pushbutton; press requests a single count step.
REQ-007 btnFast  input  1  raw asynchronous pushbutton; press toggles the fast display rate.
REQ-008 bpEnable  input  1  level; arms breakpoint compare.
REQ-009 bpValue  input  32  breakpoint count value.
REQ-010 count  input  32  current count from the downstream counter stage.
REQ-011 enable  output  1  counter free-run enable (combinational, see REQ-020).
REQ-012 step  output  1  registered one-cycle single-step pulse to the counter.
REQ-013 fast  output  1  registered fast-rate select to the counter.
REQ-014 running  output  1  registered; 1 while state is RUNNING.
REQ-015 bpHit  output  1  registered sticky breakpoint-hit flag.

Function
REQ-016 Each button SHALL pass through a 2-FF synchronizer, then a debouncer: a per-button counter counts cycles where the synchronized level differs from the accepted level, resets to 0 on any agreeing cycle, and on reaching DEBOUNCE_CYCLES updates the accepted level and clears.
REQ-017 A rising edge of an accepted level SHALL produce a one-cycle internal press pulse; falling edges and held buttons produce nothing further.
REQ-018 Total latency from a clean raw edge to press pulse SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles, +/-1.
REQ-019 State machine: STOPPED, RUNNING. STOPPED -> RUNNING on run press; RUNNING -> STOPPED on stop press or breakpoint stop; same-cycle run and stop presses: stop wins.
REQ-020 enable = (state==RUNNING) AND NOT (bpEnable AND count==bpValue AND NOT bpMask); counter therefore halts holding exactly bpValue.
REQ-021 When in RUNNING with enable forced low by the breakpoint, the next cycle SHALL be STOPPED with bpHit=1.
REQ-022 bpMask SHALL set on the run-press transition and clear on the first cycle enable=1, so resuming from a breakpoint advances past it.
REQ-023 bpHit SHALL remain 1 until the next run press or reset.
REQ-024 Step press in STOPPED SHALL assert step for exactly one cycle, state unchanged; step press in RUNNING is ignored; breakpoint does not gate step.
REQ-025 Run press while RUNNING and stop press while STOPPED SHALL be no-ops.
REQ-026 Fast press SHALL toggle fast in either state.
REQ-027 Changing bpEnable or bpValue mid-run takes effect combinationally on enable in the same cycle.

Reset
REQ-028 reset=1 SHALL force state STOPPED, enable=0, step=0, fast=0, running=0, bpHit=0, bpMask=0, all synchronizers, accepted levels, and debounce counters to 0, overriding any concurrent press.
REQ-029 Reset mid-debounce SHALL discard the partial count; a button held through reset release is accepted after a full DEBOUNCE_CYCLES window.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 btnRun high 10 cycles -> running=1 and enable=1 within 8 cycles of the edge; btnStop press -> running=0, enable=0.
REQ-031 btnStep bouncing 1-0-1 at 2-cycle spacing then held -> exactly one step pulse of width 1, running stays 0.
REQ-032 bpEnable=1, bpValue=20, run from count 0 with counter model -> count stops at 20, running=0, bpHit=1; run press -> count 21, bpHit=0.
REQ-033 btnRun and btnStop pressed simultaneously from RUNNING -> STOPPED; from STOPPED -> stays STOPPED.
REQ-034 btnFast pressed twice -> fast 0->1->0; reset asserted while RUNNING with fast=1 -> all outputs 0 next cycle.
